// File: rtl/apb_capture_pkg.sv
// rtl/apb_capture_pkg.sv - register map, field positions and status packing for apb_capture_fifo
// Purpose: shared constants and types for the capture buffer. No ports.
package apb_capture_pkg;

  // Channel register block: channel c lives at c * CH_STRIDE.
  localparam int CH_STRIDE = 16;
  localparam int CH_SHIFT  = 4;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_THRESH = 4'hC;

  localparam int ADDR_IRQSTAT = 'h100;

  // STATUS fields
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 16;
  localparam int ST_COUNT_W   = 11;

  // CTRL fields
  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_IRQEN = 2;

  localparam int THRESH_W = 11;

  typedef struct packed {
    logic [ST_COUNT_W-1:0] count;
    logic                  ovf;
    logic                  full;
    logic                  empty;
  } status_t;

  function automatic logic [31:0] pack_status(status_t s);
    logic [31:0] w;
    w = '0;
    w[ST_EMPTY] = s.empty;
    w[ST_FULL]  = s.full;
    w[ST_OVF]   = s.ovf;
    w[ST_COUNT_LSB +: ST_COUNT_W] = s.count;
    return w;
  endfunction

endpackage

// File: rtl/apb_capture_fifo_if.sv
// rtl/apb_capture_fifo_if.sv - APB3 bus bundle for apb_capture_fifo
// Purpose: groups the APB3 request/response signals.
// Signals: psel, penable, pwrite, paddr[AW], pwdata[32] (master -> slave);
//          prdata[32], pready, pslverr (slave -> master).
interface apb_capture_fifo_if #(
  parameter int AW = 12
);
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/capture_fifo.sv
// rtl/capture_fifo.sv - single-channel capture FIFO with overflow detect
// Purpose: DEPTH-entry register-array FIFO, asynchronous head read.
// Ports: clk, rst (sync, active-high); push/data (sample offer);
//        pop (consume head); flush (zero pointers and count);
//        head (current head sample); count, full, empty;
//        overflow (1-cycle pulse: sample dropped because FIFO was full).
module capture_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 64,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] data,
  input  logic          pop,
  input  logic          flush,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_pop   = pop & ~empty & ~flush;
  assign do_push  = push & ~flush & (~full | do_pop);
  assign overflow = push & ~flush & full & ~do_pop;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wptr] <= data;
  end

endmodule

// File: rtl/apb_capture_fifo.sv
// rtl/apb_capture_fifo.sv - APB3 multi-channel capture buffer with threshold/overflow IRQ
// Purpose: NCH producer FIFOs drained and controlled over APB3.
// Ports: fclk, freset (sync, active-high); apb (APB3 slave modport);
//        in_valid[NCH], in_data[NCH*DW] (producer samples, channel c at [c*DW +: DW]);
//        in_ready[NCH] (mirrors CTRL.EN); irq (registered level interrupt).
module apb_capture_fifo
  import apb_capture_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DW    = 16,
  parameter int DEPTH = 64,
  parameter int AW    = 12
) (
  input  logic                fclk,
  input  logic                freset,
  apb_capture_fifo_if.slave   apb,
  input  logic [NCH-1:0]      in_valid,
  input  logic [NCH*DW-1:0]   in_data,
  output logic [NCH-1:0]      in_ready,
  output logic                irq
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = AW - CH_SHIFT;

  logic                setup;
  logic [IW-1:0]       ch_idx;
  logic [CH_SHIFT-1:0] off;
  logic                is_irqstat;
  logic                is_ch;
  logic                off_ok;

  logic [NCH-1:0]      hit, sel, pop, flush;
  logic [NCH-1:0]      en, irqen, ovf, cause;
  logic [NCH-1:0]      full, empty, ovf_set;
  logic [THRESH_W-1:0] thresh [NCH];
  logic [CW-1:0]       count  [NCH];
  logic [DW-1:0]       head   [NCH];

  logic [31:0]         rdata;
  logic                rerr;
  logic                unused_bits;

  assign setup      = apb.psel & ~apb.penable;
  assign ch_idx     = apb.paddr[AW-1:CH_SHIFT];
  assign off        = apb.paddr[CH_SHIFT-1:0];
  assign is_irqstat = (apb.paddr == AW'(ADDR_IRQSTAT));
  assign is_ch      = ~is_irqstat & (ch_idx < IW'(NCH));
  assign off_ok     = (off == OFF_DATA) | (off == OFF_STATUS) |
                      (off == OFF_CTRL) | (off == OFF_THRESH);
  assign apb.pready = 1'b1;
  assign in_ready   = en;
  assign unused_bits = ^apb.pwdata;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic                en_q, irqen_q, ovf_q;
    logic [THRESH_W-1:0] thresh_q;

    assign hit[c]   = is_ch & (ch_idx == IW'(c));
    assign sel[c]   = setup & hit[c];
    assign pop[c]   = sel[c] & ~apb.pwrite & (off == OFF_DATA) & ~empty[c];
    assign flush[c] = sel[c] & apb.pwrite & (off == OFF_CTRL) & apb.pwdata[CTRL_FLUSH];

    assign en[c]     = en_q;
    assign irqen[c]  = irqen_q;
    assign ovf[c]    = ovf_q;
    assign thresh[c] = thresh_q;

    // THRESH of 0 compares true for every count, so the cause is then IRQEN alone.
    assign cause[c] = irqen_q & ((THRESH_W'(count[c]) >= thresh_q) | ovf_q);

    capture_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (fclk),
      .rst      (freset),
      .push     (in_valid[c] & en_q),
      .data     (in_data[c*DW +: DW]),
      .pop      (pop[c]),
      .flush    (flush[c]),
      .head     (head[c]),
      .count    (count[c]),
      .full     (full[c]),
      .empty    (empty[c]),
      .overflow (ovf_set[c])
    );

    always_ff @(posedge fclk) begin
      if (freset) begin
        en_q     <= 1'b0;
        irqen_q  <= 1'b0;
        ovf_q    <= 1'b0;
        thresh_q <= THRESH_W'(DEPTH / 2);
      end else begin
        if (sel[c] && apb.pwrite) begin
          case (off)
            OFF_CTRL: begin
              en_q    <= apb.pwdata[CTRL_EN];
              irqen_q <= apb.pwdata[CTRL_IRQEN];
            end
            OFF_THRESH: thresh_q <= apb.pwdata[THRESH_W-1:0];
            OFF_STATUS: if (apb.pwdata[ST_OVF]) ovf_q <= 1'b0;
            default: ;
          endcase
        end
        // A drop in the same cycle as a clear leaves OVF set.
        if (ovf_set[c]) ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    rerr  = 1'b0;
    if (is_irqstat) begin
      rdata = 32'(cause);
    end else if (!(is_ch && off_ok)) begin
      rerr = 1'b1;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (hit[c]) begin
          case (off)
            OFF_DATA: begin
              if (empty[c]) rerr = ~apb.pwrite;
              else          rdata = 32'(head[c]);
            end
            OFF_STATUS: rdata = pack_status('{count: ST_COUNT_W'(count[c]),
                                              ovf:   ovf[c],
                                              full:  full[c],
                                              empty: empty[c]});
            OFF_CTRL: begin
              rdata[CTRL_EN]    = en[c];
              rdata[CTRL_IRQEN] = irqen[c];
            end
            OFF_THRESH: rdata = 32'(thresh[c]);
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge fclk) begin
    if (freset) begin
      apb.prdata  <= '0;
      apb.pslverr <= 1'b0;
      irq         <= 1'b0;
    end else begin
      irq <= |cause;
      if (setup) begin
        apb.prdata  <= apb.pwrite ? 32'h0 : rdata;
        apb.pslverr <= rerr;
      end
    end
  end

endmodule

// File: tb/tb_apb_capture_fifo.sv
// tb/tb_apb_capture_fifo.sv - directed self-checking bench for apb_capture_fifo
module tb_apb_capture_fifo;

  localparam int NCH   = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic              irq;

  logic [31:0] d;
  logic        e;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  apb_capture_fifo_if #(.AW(AW)) apb ();

  apb_capture_fifo #(
    .NCH   (NCH),
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .fclk     (clk),
    .freset   (rst),
    .apb      (apb),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .irq      (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Full APB transfer starting at a negedge; vmask drives in_valid during the setup edge only.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                      input logic [NCH-1:0] vmask, input logic [DW-1:0] vdata,
                      output logic [31:0] rdata, output logic err);
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = wr;
    apb.paddr   = addr;
    apb.pwdata  = wdata;
    in_valid    = vmask;
    in_data     = {NCH{vdata}};
    @(negedge clk);
    apb.penable = 1'b1;
    in_valid    = '0;
    rdata       = apb.prdata;
    err         = apb.pslverr;
    @(negedge clk);
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] addr,
                        input logic [31:0] exp_d, input logic exp_e);
    xfer(1'b0, addr, 32'h0, '0, '0, d, e);
    check(tag, d, exp_d);
    check({tag, "_err"}, 32'(e), 32'(exp_e));
  endtask

  task automatic wr_chk(input string tag, input logic [AW-1:0] addr,
                        input logic [31:0] data, input logic exp_e);
    xfer(1'b1, addr, data, '0, '0, d, e);
    check({tag, "_err"}, 32'(e), 32'(exp_e));
  endtask

  task automatic push(input int ch, input logic [DW-1:0] data);
    in_valid[ch] = 1'b1;
    in_data[ch*DW +: DW] = data;
    @(negedge clk);
    in_valid = '0;
  endtask

  initial begin
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0;  apb.pwdata = '0;
    in_valid = '0;   in_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_prdata", apb.prdata, 32'h0);
    check("rst_pslverr", 32'(apb.pslverr), 32'h0);
    check("rst_pready", 32'(apb.pready), 32'h1);
    for (int c = 0; c < NCH; c++) begin
      rd_chk($sformatf("rst_status%0d", c), AW'(c*16 + 4),  32'h1,  1'b0);
      rd_chk($sformatf("rst_ctrl%0d", c),   AW'(c*16 + 8),  32'h0,  1'b0);
      rd_chk($sformatf("rst_thresh%0d", c), AW'(c*16 + 12), 32'h20, 1'b0);
    end
    rd_chk("rst_irqstat", 12'h100, 32'h0, 1'b0);

    // ch1 basic ordering and empty read
    wr_chk("ch1_en", 12'h018, 32'h1, 1'b0);
    check("ch1_in_ready", 32'(in_ready), 32'h2);
    for (int i = 1; i <= 5; i++) push(1, DW'(i));
    for (int i = 1; i <= 5; i++) rd_chk($sformatf("ch1_pop%0d", i), 12'h010, 32'(i), 1'b0);
    rd_chk("ch1_empty_pop", 12'h010, 32'h0, 1'b1);
    rd_chk("ch1_status", 12'h014, 32'h1, 1'b0);

    // ch0 overflow
    wr_chk("ch0_en", 12'h008, 32'h1, 1'b0);
    for (int k = 0; k <= 64; k++) push(0, DW'(16'h0100 + k));
    rd_chk("ch0_ovf_status", 12'h004, 32'h0040_0006, 1'b0);
    wr_chk("ch0_ovf_clr", 12'h004, 32'h4, 1'b0);
    rd_chk("ch0_status_clr", 12'h004, 32'h0040_0002, 1'b0);
    for (int k = 0; k < 64; k++) rd_chk($sformatf("ch0_pop%0d", k), 12'h000, 32'h0100 + k, 1'b0);
    rd_chk("ch0_lost65", 12'h000, 32'h0, 1'b1);

    // ch2 full with same-cycle push and pop
    wr_chk("ch2_en", 12'h028, 32'h1, 1'b0);
    for (int k = 0; k < 64; k++) push(2, DW'(16'h0200 + k));
    xfer(1'b0, 12'h020, 32'h0, 4'b0100, 16'h02FF, d, e);
    check("ch2_pushpop_data", d, 32'h0200);
    check("ch2_pushpop_err", 32'(e), 32'h0);
    rd_chk("ch2_status", 12'h024, 32'h0040_0002, 1'b0);
    for (int k = 1; k < 64; k++) rd_chk($sformatf("ch2_pop%0d", k), 12'h020, 32'h0200 + k, 1'b0);
    rd_chk("ch2_last", 12'h020, 32'h02FF, 1'b0);
    rd_chk("ch2_empty", 12'h020, 32'h0, 1'b1);

    // ch3 threshold interrupt
    wr_chk("ch3_thresh", 12'h03C, 32'h3, 1'b0);
    wr_chk("ch3_ctrl", 12'h038, 32'h5, 1'b0);
    push(3, 16'h00A1);
    push(3, 16'h00A2);
    check("irq_after2", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_after2_b", 32'(irq), 32'h0);
    in_valid[3] = 1'b1;
    in_data[3*DW +: DW] = 16'h00A3;
    @(negedge clk);
    in_valid = '0;
    check("irq_lat0", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_lat1", 32'(irq), 32'h1);
    rd_chk("irqstat_set", 12'h100, 32'h8, 1'b0);
    rd_chk("ch3_pop", 12'h030, 32'h00A1, 1'b0);
    check("irq_cleared", 32'(irq), 32'h0);
    rd_chk("irqstat_clr", 12'h100, 32'h0, 1'b0);

    // ch0 flush with same-cycle push, then error decode
    for (int k = 0; k < 10; k++) push(0, DW'(16'h0300 + k));
    rd_chk("ch0_10", 12'h004, 32'h000A_0000, 1'b0);
    xfer(1'b1, 12'h008, 32'h3, 4'b0001, 16'h03FF, d, e);
    check("flush_err", 32'(e), 32'h0);
    rd_chk("flush_status", 12'h004, 32'h1, 1'b0);
    rd_chk("flush_ctrl", 12'h008, 32'h1, 1'b0);
    rd_chk("unmapped_200", 12'h200, 32'h0, 1'b1);
    rd_chk("unmapped_ch4", 12'h040, 32'h0, 1'b1);
    rd_chk("unaligned", 12'h006, 32'h0, 1'b1);
    wr_chk("wr_unmapped", 12'h200, 32'h1, 1'b1);
    wr_chk("wr_irqstat", 12'h100, 32'hF, 1'b0);
    wr_chk("wr_data_ro", 12'h000, 32'h55, 1'b0);
    rd_chk("ro_status", 12'h004, 32'h1, 1'b0);

    // Reset during a transfer
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 12'h03C;
    rst = 1'b1;
    @(negedge clk);
    apb.penable = 1'b1;
    rst = 1'b0;
    check("midrst_prdata", apb.prdata, 32'h0);
    check("midrst_pslverr", 32'(apb.pslverr), 32'h0);
    @(negedge clk);
    apb.psel = 1'b0; apb.penable = 1'b0;
    rd_chk("midrst_thresh", 12'h03C, 32'h20, 1'b0);
    rd_chk("midrst_status", 12'h034, 32'h1, 1'b0);
    check("midrst_in_ready", 32'(in_ready), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
